basic_monitor: RTL

BASIC_MONITOR -- requirements
Module: basic_monitor

---
 rtl/basic_mon_pkg.sv | 14 +
 rtl/sat_counter.sv | 25 ++
 rtl/basic_monitor.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/basic_mon_pkg.sv
// Shared types and default constants for the z1/z2 response monitor.
package basic_mon_pkg;

  localparam int WIN_DEFAULT = 4;
  localparam int CW_DEFAULT  = 8;
  localparam int PEND_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FAIL = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr has priority over inc.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/basic_monitor.sv
// Watches the upstream status bus: z1-to-z2 response window, mutual-exclusion
// check between z1 and z2, and saturating pulse/run statistics.
module basic_monitor
  import basic_mon_pkg::*;
#(
  parameter int WIN = WIN_DEFAULT,
  parameter int CW  = CW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [3:0]        z,
  output logic              busy,
  output logic              fail,
  output logic              mutex_err,
  output logic [CW-1:0]     z1_cnt,
  output logic [CW-1:0]     z2_cnt,
  output logic [CW-1:0]     z3_max_run,
  output logic [PEND_W-1:0] pend
);

  localparam logic [PEND_W-1:0] WIN_LD  = PEND_W'(WIN);
  localparam logic [CW-1:0]     CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              fail_q, fail_d;
  logic              mutex_q;
  logic [CW-1:0]     run_cnt, run_next, max_q;
  logic              sample;
  logic              unused_z0;

  assign sample    = en & ~clr;
  assign unused_z0 = z[0];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    fail_d  = fail_q;
    if (clr) begin
      state_d = IDLE;
      pend_d  = '0;
      fail_d  = 1'b0;
    end else if (en) begin
      unique case (state_q)
        IDLE: begin
          if (z[1]) begin
            state_d = WAIT;
            pend_d  = WIN_LD;
          end
        end
        WAIT: begin
          // z2 closes the window even when z1 retriggers in the same sample.
          if (z[2]) begin
            state_d = IDLE;
            pend_d  = '0;
          end else if (z[1]) begin
            pend_d = WIN_LD;
          end else if (pend_q == PEND_W'(1)) begin
            state_d = FAIL;
            pend_d  = '0;
            fail_d  = 1'b1;
          end else begin
            pend_d = pend_q - PEND_W'(1);
          end
        end
        FAIL: ;
        default: begin
          state_d = IDLE;
          pend_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      fail_q  <= fail_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mutex_q <= 1'b0;
    end else if (clr) begin
      mutex_q <= 1'b0;
    end else if (sample && z[1] && z[2]) begin
      mutex_q <= 1'b1;
    end
  end

  sat_counter #(.W(CW)) u_z1_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (sample & z[1]),
    .cnt   (z1_cnt)
  );

  sat_counter #(.W(CW)) u_z2_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (sample & z[2]),
    .cnt   (z2_cnt)
  );

  // Current z3 run restarts on any sampled low.
  sat_counter #(.W(CW)) u_run_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr | (sample & ~z[3])),
    .inc   (sample & z[3]),
    .cnt   (run_cnt)
  );

  assign run_next = (run_cnt == CNT_MAX) ? run_cnt : run_cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
    end else if (clr) begin
      max_q <= '0;
    end else if (sample && z[3] && (run_next > max_q)) begin
      max_q <= run_next;
    end
  end

  assign busy       = (state_q == WAIT);
  assign fail       = fail_q;
  assign mutex_err  = mutex_q;
  assign pend       = pend_q;
  assign z3_max_run = max_q;

endmodule
